// File: rtl/stepper_pulse_scheduler.sv
// stepper_pulse_scheduler: turns signed per-period step demand into rate-limited step/dir pulses.
// Ports: clock/reset (async, active-high); delta_valid/delta_steps add signed steps to the
// pending accumulator; flush discards pending; step/dir drive the stepper IC; busy is high
// while a pulse/setup is in progress or steps are pending; overflow is sticky on saturation;
// position counts issued steps when STEP_POSITION_EN is defined, otherwise it is tied to 0.
module stepper_pulse_scheduler #(
  parameter int DELTA_BITS = 16,
  parameter int PEND_BITS  = 20,
  parameter int PULSE_HIGH = 100,
  parameter int PULSE_LOW  = 100,
  parameter int DIR_SETUP  = 250,
  parameter int POS_BITS   = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         delta_valid,
  input  logic signed [DELTA_BITS-1:0] delta_steps,
  input  logic                         flush,
  output logic                         step,
  output logic                         dir,
  output logic                         busy,
  output logic                         overflow,
  output logic signed [POS_BITS-1:0]   position
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  localparam int TMAX = DIR_SETUP > PULSE_HIGH ? (DIR_SETUP > PULSE_LOW ? DIR_SETUP : PULSE_LOW)
                                               : (PULSE_HIGH > PULSE_LOW ? PULSE_HIGH : PULSE_LOW);
  localparam int TW = $clog2(TMAX + 1);
  // Two guard bits so pending + delta - issue never wraps before saturation.
  localparam int SW = (DELTA_BITS > PEND_BITS ? DELTA_BITS : PEND_BITS) + 2;
  localparam logic signed [SW-1:0] PMAX = (SW'(1) <<< (PEND_BITS - 1)) - SW'(1);
  localparam logic signed [SW-1:0] NMAX = -PMAX;
  localparam logic signed [SW-1:0] P1 = 1;
  localparam logic signed [SW-1:0] M1 = -1;
  state_t                       state_q, state_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic signed [PEND_BITS-1:0]  pending_q, pending_d;
  logic                         step_q, step_d, dir_q, dir_d, ovf_q, ovf_d;
  logic signed [SW-1:0]         sum;
  logic                         want, rise;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = step_q;
    dir_d   = dir_q;
    rise    = 1'b0;
    want    = ~pending_q[PEND_BITS-1];
    case (state_q)
      IDLE:
        if (!flush && pending_q != '0) begin
          if (want != dir_q) begin
            dir_d   = want;
            timer_d = TW'(DIR_SETUP - 1);
            state_d = SETUP;
          end else rise = 1'b1;
        end
      SETUP:
        // Demand vanished or reversed while dir was settling: abandon without a pulse.
        if (flush || pending_q == '0 || want != dir_q) state_d = IDLE;
        else if (timer_q == '0) rise = 1'b1;
        else timer_d = timer_q - 1'b1;
      HIGH:
        if (timer_q == '0) begin
          step_d  = 1'b0;
          timer_d = TW'(PULSE_LOW - 1);
          state_d = LOW;
        end else timer_d = timer_q - 1'b1;
      LOW:
        if (timer_q == '0) state_d = IDLE;
        else timer_d = timer_q - 1'b1;
    endcase
    if (rise) begin
      step_d  = 1'b1;
      timer_d = TW'(PULSE_HIGH - 1);
      state_d = HIGH;
    end
    sum = SW'(pending_q) + (delta_valid ? SW'(delta_steps) : '0) - (rise ? (dir_q ? P1 : M1) : '0);
    pending_d = flush ? '0 : sum > PMAX ? PMAX[PEND_BITS-1:0] : sum < NMAX ? NMAX[PEND_BITS-1:0]
                                                              : sum[PEND_BITS-1:0];
    ovf_d = ovf_q | (!flush && (sum > PMAX || sum < NMAX));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      ovf_q     <= ovf_d;
    end
  end
  assign step     = step_q;
  assign dir      = dir_q;
  assign overflow = ovf_q;
  assign busy     = state_q != IDLE || pending_q != '0;
`ifdef STEP_POSITION_EN
  logic signed [POS_BITS-1:0] position_q, position_d;
  always_comb position_d = rise ? position_q + (dir_q ? POS_BITS'(1) : {POS_BITS{1'b1}}) : position_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) position_q <= '0;
    else position_q <= position_d;
  end
  assign position = position_q;
`else
  assign position = '0;
`endif
endmodule

// File: tb/tb_stepper_pulse_scheduler.sv
// tb_stepper_pulse_scheduler: randomized bench against an event-time reference model.
module tb_stepper_pulse_scheduler;
  localparam int DB = 16, PB = 8, PH = 4, PL = 3, DS = 6, POSB = 32;
  localparam int PMAX = (1 << (PB - 1)) - 1;
  logic clock = 1'b0, reset = 1'b0, delta_valid = 1'b0, flush = 1'b0;
  logic signed [DB-1:0] delta_steps = '0;
  logic step, dir, busy, overflow;
  logic signed [POSB-1:0] position;
  int n_chk = 0, n_pass = 0;
  int k = 0;
  int pend, mpos, idle_at, setup_end, fall_at;
  bit mdir, mstep, movf;
  always #5 clock = ~clock;
  stepper_pulse_scheduler #(.DELTA_BITS(DB), .PEND_BITS(PB), .PULSE_HIGH(PH), .PULSE_LOW(PL),
                            .DIR_SETUP(DS), .POS_BITS(POSB)) dut (
    .clock(clock), .reset(reset), .delta_valid(delta_valid), .delta_steps(delta_steps),
    .flush(flush), .step(step), .dir(dir), .busy(busy), .overflow(overflow), .position(position));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, $signed(got), $signed(exp), k);
  endtask
  task automatic model_reset();
    pend = 0; mpos = 0; mdir = 0; mstep = 0; movf = 0;
    idle_at = 0; setup_end = -1; fall_at = -1;
  endtask
  // Pulses are tracked as timestamps: a rise at edge t holds step high until edge t+PH and
  // frees the scheduler for a new decision at edge t+PH+PL+1; a dir change at edge t allows
  // the rise at edge t+DS at the earliest.
  task automatic model_edge(input bit dv, input int dd, input bit fl);
    int iss, s;
    bit fire;
    iss = 0;
    fire = 0;
    if (k < idle_at) begin
      if (k == fall_at) mstep = 0;
    end else if (setup_end >= 0) begin
      if (fl || pend == 0 || ((pend > 0) != mdir)) setup_end = -1;
      else if (k == setup_end) fire = 1;
    end else if (!fl && pend != 0) begin
      if ((pend > 0) != mdir) begin
        mdir = pend > 0;
        setup_end = k + DS;
      end else fire = 1;
    end
    if (fire) begin
      mstep = 1;
      iss = mdir ? 1 : -1;
      mpos += iss;
      fall_at = k + PH;
      idle_at = k + PH + PL + 1;
      setup_end = -1;
    end
    if (fl) pend = 0;
    else begin
      s = pend + (dv ? dd : 0) - iss;
      if (s > PMAX) begin s = PMAX; movf = 1; end
      else if (s < -PMAX) begin s = -PMAX; movf = 1; end
      pend = s;
    end
    k++;
  endtask
  task automatic check_all();
    check("step", step, mstep);
    check("dir", dir, mdir);
    check("busy", busy, k < idle_at || setup_end >= 0 || pend != 0);
    check("overflow", overflow, movf);
`ifdef STEP_POSITION_EN
    check("position", position, mpos);
`else
    check("position", position, 0);
`endif
  endtask
  task automatic cycle(input bit dv, input int dd, input bit fl);
    @(negedge clock);
    delta_valid = dv;
    delta_steps = DB'(dd);
    flush = fl;
    @(posedge clock);
    model_edge(dv, dd, fl);
    #1 check_all();
  endtask
  task automatic run(input int n, input int pdv, input int r, input int pfl);
    bit dv, fl;
    int dd;
    for (int i = 0; i < n; i++) begin
      dv = $urandom_range(0, 999) < pdv;
      fl = $urandom_range(0, 999) < pfl;
      dd = int'($urandom_range(0, 2 * r)) - r;
      cycle(dv, dd, fl);
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    delta_valid = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    model_edge(0, 0, 0);
    #1 check_all();
  endtask
  task automatic wait_step(input string tag);
    int n;
    n = 0;
    while (!mstep && n < 100) begin
      cycle(0, 0, 0);
      n++;
    end
    check(tag, step, 1);
  endtask
  initial begin
    model_reset();
    do_reset();
    cycle(1, 3, 0);
    run(40, 0, 0, 0);
    cycle(1, 2, 0);
    wait_step("rev_first_pulse");
    cycle(1, -5, 0);
    run(80, 0, 0, 0);
    cycle(1, 100, 0);
    cycle(1, 100, 0);
    run(1100, 0, 0, 0);
    run(800, 60, 3, 5);
    run(800, 15, 200, 2);
    run(800, 10, 2, 10);
    cycle(1, 10, 0);
    wait_step("flush_pulse");
    cycle(0, 0, 1);
    run(30, 0, 0, 0);
    cycle(1, 2, 0);
    wait_step("reset_pulse");
    do_reset();
    run(30, 0, 0, 0);
    run(600, 20, 4, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
